// File: rtl/l2_arbiter.sv
// l2_arbiter: two-requester (icache / dcache) arbiter in front of a shared L2.
// Exactly one transaction is outstanding at L2. The winner's command, address
// and write data are captured on grant and held until L2_resp.
// Optional macro L2_ARB_ROUND_ROBIN_EN: simultaneous requests alternate
// against last_grant. When the macro is undefined, dcache wins every conflict.
//
// Handshake: a requester raises its read/write and holds it with a stable
// address (and wdata) until it sees its one-cycle resp pulse. The arbiter
// samples requests only in IDLE. L2 sees a command held constant until
// L2_resp, which completes the transaction in that same cycle. rdata is
// valid only in the cycle where resp is high.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_l2_read,
  input  logic [ADDR_WIDTH-1:0] icache_l2_address,
  output logic [LINE_WIDTH-1:0] icache_l2_rdata,
  output logic                  icache_l2_resp,
  input  logic                  dcache_l2_read,
  input  logic                  dcache_l2_write,
  input  logic [ADDR_WIDTH-1:0] dcache_l2_address,
  input  logic [LINE_WIDTH-1:0] dcache_l2_wdata,
  output logic [LINE_WIDTH-1:0] dcache_l2_rdata,
  output logic                  dcache_l2_resp,
  output logic                  L2_read,
  output logic                  L2_write,
  output logic [ADDR_WIDTH-1:0] L2_address,
  output logic [LINE_WIDTH-1:0] L2_wdata,
  input  logic [LINE_WIDTH-1:0] L2_rdata,
  input  logic                  L2_resp,
  output logic                  grant_i,
  output logic                  grant_d,
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  read_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  req_i;
  logic                  req_d;
  logic                  pick_d;

  // Decide which requester would win if the arbiter is idle this cycle.
  always_comb begin
    req_i = icache_l2_read;
    req_d = dcache_l2_read | dcache_l2_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
    pick_d = req_d && (!req_i || (last_grant == OWNER_I));
`else
    pick_d = req_d;
`endif
  end

  // FSM plus the registered L2 command; reset overrides everything, including L2_resp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= OWNER_I;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state   <= SERVE_D;
            addr_q  <= dcache_l2_address;
            wdata_q <= dcache_l2_wdata;
            // A write-back takes precedence over a fill raised together with it.
            write_q <= dcache_l2_write;
            read_q  <= ~dcache_l2_write;
          end else if (req_i) begin
            state   <= SERVE_I;
            addr_q  <= icache_l2_address;
            read_q  <= 1'b1;
            write_q <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (L2_resp) begin
            state      <= IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            last_grant <= (state == SERVE_D) ? OWNER_D : OWNER_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign L2_read         = read_q;
  assign L2_write        = write_q;
  assign L2_address      = addr_q;
  assign L2_wdata        = wdata_q;
  assign grant_i         = (state == SERVE_I);
  assign grant_d         = (state == SERVE_D);
  // Gating with rst_n keeps a completion that coincides with reset from reaching the requester.
  assign icache_l2_resp  = rst_n & grant_i & L2_resp;
  assign dcache_l2_resp  = rst_n & grant_d & L2_resp;
  assign icache_l2_rdata = L2_rdata;
  assign dcache_l2_rdata = L2_rdata;
  assign fsm_state       = state;

endmodule

// File: tb/tb_l2_arbiter.sv
// Testbench for l2_arbiter: directed scenarios plus randomized rounds, each
// compared against a transaction-level model of who should own L2 next.
// The model follows L2_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
`ifdef L2_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          icache_l2_read;
  logic [AW-1:0] icache_l2_address;
  logic [LW-1:0] icache_l2_rdata;
  logic          icache_l2_resp;
  logic          dcache_l2_read;
  logic          dcache_l2_write;
  logic [AW-1:0] dcache_l2_address;
  logic [LW-1:0] dcache_l2_wdata;
  logic [LW-1:0] dcache_l2_rdata;
  logic          dcache_l2_resp;
  logic          L2_read;
  logic          L2_write;
  logic [AW-1:0] L2_address;
  logic [LW-1:0] L2_wdata;
  logic [LW-1:0] L2_rdata;
  logic          L2_resp;
  logic          grant_i;
  logic          grant_d;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  // Model state: owner of the most recently completed transaction (1 = dcache).
  bit last_d = 1'b0;

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_l2_read(icache_l2_read), .icache_l2_address(icache_l2_address),
    .icache_l2_rdata(icache_l2_rdata), .icache_l2_resp(icache_l2_resp),
    .dcache_l2_read(dcache_l2_read), .dcache_l2_write(dcache_l2_write),
    .dcache_l2_address(dcache_l2_address), .dcache_l2_wdata(dcache_l2_wdata),
    .dcache_l2_rdata(dcache_l2_rdata), .dcache_l2_resp(dcache_l2_resp),
    .L2_read(L2_read), .L2_write(L2_write), .L2_address(L2_address),
    .L2_wdata(L2_wdata), .L2_rdata(L2_rdata), .L2_resp(L2_resp),
    .grant_i(grant_i), .grant_d(grant_d), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Everything that must be quiet when nobody owns L2.
  task automatic check_idle(input string name);
    checks++;
    if ({grant_i, grant_d, L2_read, L2_write, icache_l2_resp, dcache_l2_resp} !== 6'b0) begin
      errors++;
      $display("FAIL %s idle: gi=%b gd=%b rd=%b wr=%b ir=%b dr=%b expected all 0", name,
               grant_i, grant_d, L2_read, L2_write, icache_l2_resp, dcache_l2_resp);
    end
  endtask

  // One arbitration round starting from IDLE at a negedge. Requests are
  // driven here; addresses/wdata are taken from whatever the caller left on
  // the inputs. perturb: 0 none, 1 random input churn and request drops
  // mid-serve, 2 move the dcache address to 0x9990 mid-serve.
  task automatic do_round(input string name, input bit ri, input bit drd, input bit dwr,
                          input int lat, input int perturb);
    bit            rd;
    bit            win_d;
    bit            exp_rd;
    bit            exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata;
    logic [LW-1:0] rdat;
    logic [LW-1:0] got_rdata;
    rd = drd | dwr;
    icache_l2_read  = ri;
    dcache_l2_read  = drd;
    dcache_l2_write = dwr;
    if (!ri && !rd) begin
      next_cycle();
      check_idle({name, "_none"});
      return;
    end
    if (ri && rd) win_d = RR ? !last_d : 1'b1;
    else          win_d = rd;
    exp_wr    = win_d && dwr;
    exp_rd    = !exp_wr;
    exp_addr  = win_d ? dcache_l2_address : icache_l2_address;
    exp_wdata = dcache_l2_wdata;
    next_cycle();
    for (int k = 0; k <= lat; k++) begin
      checks++;
      if (grant_d !== win_d || grant_i !== !win_d) begin
        errors++;
        $display("FAIL %s grant k=%0d: gi=%b gd=%b expected gi=%b gd=%b", name, k,
                 grant_i, grant_d, !win_d, win_d);
      end
      checks++;
      if (L2_read !== exp_rd || L2_write !== exp_wr) begin
        errors++;
        $display("FAIL %s cmd k=%0d: rd=%b wr=%b expected rd=%b wr=%b", name, k,
                 L2_read, L2_write, exp_rd, exp_wr);
      end
      checks++;
      if (L2_address !== exp_addr) begin
        errors++;
        $display("FAIL %s addr k=%0d: got %h expected %h", name, k, L2_address, exp_addr);
      end
      if (exp_wr) begin
        checks++;
        if (L2_wdata !== exp_wdata) begin
          errors++;
          $display("FAIL %s wdata k=%0d: got %h expected %h", name, k, L2_wdata, exp_wdata);
        end
      end
      if (k == lat) break;
      checks++;
      if (icache_l2_resp !== 1'b0 || dcache_l2_resp !== 1'b0) begin
        errors++;
        $display("FAIL %s early_resp k=%0d: ir=%b dr=%b expected 0 0", name, k,
                 icache_l2_resp, dcache_l2_resp);
      end
      if (perturb == 1) begin
        icache_l2_address = AW'($urandom);
        dcache_l2_address = AW'($urandom);
        dcache_l2_wdata   = rand_line();
        if ($urandom_range(0, 3) == 0) begin
          if (win_d) begin
            dcache_l2_read  = 1'b0;
            dcache_l2_write = 1'b0;
          end else begin
            icache_l2_read = 1'b0;
          end
        end
      end else if (perturb == 2) begin
        dcache_l2_address = 16'h9990;
      end
      next_cycle();
    end
    rdat     = rand_line();
    L2_rdata = rdat;
    L2_resp  = 1'b1;
    #1;
    checks++;
    if (dcache_l2_resp !== win_d || icache_l2_resp !== !win_d) begin
      errors++;
      $display("FAIL %s resp: ir=%b dr=%b expected ir=%b dr=%b", name,
               icache_l2_resp, dcache_l2_resp, !win_d, win_d);
    end
    got_rdata = win_d ? dcache_l2_rdata : icache_l2_rdata;
    checks++;
    if (got_rdata !== rdat) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", name, got_rdata, rdat);
    end
    next_cycle();
    L2_resp         = 1'b0;
    icache_l2_read  = 1'b0;
    dcache_l2_read  = 1'b0;
    dcache_l2_write = 1'b0;
    last_d          = win_d;
    check_idle(name);
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    icache_l2_read    = 1'b1;
    dcache_l2_write   = 1'b1;
    icache_l2_address = 16'h1111;
    dcache_l2_address = 16'h2222;
    dcache_l2_wdata   = rand_line();
    L2_resp           = 1'b1;
    repeat (2) next_cycle();
    check_idle("reset");
    checks++;
    if (L2_address !== '0 || L2_wdata !== '0) begin
      errors++;
      $display("FAIL reset regs: addr=%h wdata=%h expected 0", L2_address, L2_wdata);
    end
    icache_l2_read  = 1'b0;
    dcache_l2_write = 1'b0;
    L2_resp         = 1'b0;
    rst_n           = 1'b1;
    last_d          = 1'b0;
    next_cycle();
    check_idle("post_reset");
  endtask

  task automatic test_icache_read();
    icache_l2_address = 16'h1230;
    do_round("icache_read", 1'b1, 1'b0, 1'b0, 3, 0);
  endtask

  task automatic test_dcache_write();
    dcache_l2_address = 16'h4440;
    dcache_l2_wdata   = {16{8'hA5}};
    do_round("dcache_write", 1'b0, 1'b0, 1'b1, 2, 0);
  endtask

  task automatic test_addr_hold();
    dcache_l2_address = 16'h4440;
    do_round("addr_hold", 1'b0, 1'b1, 1'b0, 3, 2);
  endtask

  task automatic test_read_write_both();
    dcache_l2_address = 16'h0abc;
    dcache_l2_wdata   = rand_line();
    do_round("rw_both", 1'b0, 1'b1, 1'b1, 1, 0);
  endtask

  task automatic test_reset_mid_serve();
    icache_l2_address = 16'h7770;
    icache_l2_read    = 1'b1;
    next_cycle();
    checks++;
    if (grant_i !== 1'b1 || L2_read !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid grant: gi=%b rd=%b expected 1 1", grant_i, L2_read);
    end
    L2_resp = 1'b1;
    rst_n   = 1'b0;
    #1;
    checks++;
    if (icache_l2_resp !== 1'b0 || dcache_l2_resp !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid resp: ir=%b dr=%b expected 0 0", icache_l2_resp, dcache_l2_resp);
    end
    next_cycle();
    check_idle("rst_mid");
    checks++;
    if (L2_address !== '0 || L2_wdata !== '0) begin
      errors++;
      $display("FAIL rst_mid regs: addr=%h wdata=%h expected 0", L2_address, L2_wdata);
    end
    rst_n          = 1'b1;
    L2_resp        = 1'b0;
    icache_l2_read = 1'b0;
    last_d         = 1'b0;
    next_cycle();
    check_idle("rst_mid_after");
  endtask

  task automatic test_conflict();
    for (int n = 0; n < 3; n++) begin
      icache_l2_address = AW'($urandom);
      dcache_l2_address = AW'($urandom);
      dcache_l2_wdata   = rand_line();
      do_round("conflict", 1'b1, 1'b1, n[0], 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 150; n++) begin
      icache_l2_address = AW'($urandom);
      dcache_l2_address = AW'($urandom);
      dcache_l2_wdata   = rand_line();
      do_round("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1);
    end
  endtask

  // Test sequence
  initial begin
    rst_n             = 1'b0;
    icache_l2_read    = 1'b0;
    icache_l2_address = '0;
    dcache_l2_read    = 1'b0;
    dcache_l2_write   = 1'b0;
    dcache_l2_address = '0;
    dcache_l2_wdata   = '0;
    L2_rdata          = '0;
    L2_resp           = 1'b0;
    @(negedge clk);
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_addr_hold();
    test_read_write_both();
    test_reset_mid_serve();
    test_conflict();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
